io_event_arbiter: RTL and testbench

Shares the single CPU interrupt/event path between several I/O event sources: the key device, the timer device, and future peripherals.
- Each source emits a one-cycle irq pulse with a 32-bit event word, e.g. key events {8'd1,8'd0,8'd0,3'b0,keys}.
- The block latches each event per source and serialises pending events round-robin into a small FIFO.
- It presents the FIFO head to the CPU with a level interrupt and an acknowledge/pop handshake.
- Dropped events are counted.

---
 rtl/io_evt_pkg.sv | 24 ++
 rtl/io_evt_fifo.sv | 57 +++++
 rtl/io_event_arbiter.sv | 111 +++++++++++
 tb/tb_io_event_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/io_evt_pkg.sv
// Shared definitions for the I/O event path: event-word layout, type codes
// and the overflow-counter ceiling.
package io_evt_pkg;

    // Event-word field positions
    localparam int unsigned EVT_TYPE_MSB    = 31;
    localparam int unsigned EVT_TYPE_LSB    = 24;
    localparam int unsigned EVT_PAYLOAD_MSB = 7;
    localparam int unsigned EVT_PAYLOAD_LSB = 0;

    // Event type codes
    localparam logic [7:0] EVT_KEY   = 8'd1;
    localparam logic [7:0] EVT_TIMER = 8'd2;

    localparam logic [7:0] OVF_MAX = 8'd255;

    // Add up to 15 drops to an 8-bit counter, clamping at OVF_MAX.
    function automatic logic [7:0] sat_add8(input logic [7:0] base, input logic [3:0] inc);
        logic [8:0] sum;
        sum = {1'b0, base} + {5'b0, inc};
        return (sum > {1'b0, OVF_MAX}) ? OVF_MAX : sum[7:0];
    endfunction

endpackage

// File: rtl/io_evt_fifo.sv
// Circular-buffer FIFO holding serialised event words; head is forced to zero
// while empty so consumers never see stale data.
module io_evt_fifo #(
    parameter int unsigned W     = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [W-1:0]               push_data,
    input  logic                       pop,
    output logic [W-1:0]               head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign count   = count_q;
    assign head    = empty ? '0 : mem[rd_ptr_q];

    // Pointers wrap naturally; count tracks occupancy with one extra bit for full
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: head is masked while empty
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/io_event_arbiter.sv
// Latches one-cycle event pulses per source, serialises them round-robin
// into a FIFO and presents the head to the CPU with a level interrupt.
module io_event_arbiter
    import io_evt_pkg::*;
#(
    parameter int unsigned NSRC  = 4,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned W     = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NSRC-1:0]        src_irq,
    input  logic [NSRC*W-1:0]      src_data,
    output logic                   cpu_irq,
    output logic [W-1:0]           cpu_data,
    input  logic                   cpu_ack,
    input  logic                   clr_ovf,
    output logic [7:0]             ovf_cnt,
    output logic [NSRC-1:0]        pending,
    output logic [$clog2(DEPTH):0] fifo_level
);

    localparam int unsigned PW = $clog2(NSRC);

    logic [W-1:0]    slot_q [NSRC];
    logic [NSRC-1:0] pend_q, pend_d;
    logic [PW-1:0]   rr_ptr_q;
    logic [7:0]      ovf_q, ovf_d;
    logic [NSRC-1:0] latch_en;
    logic [NSRC-1:0] gnt_vec;
    logic [3:0]      drop_cnt;
    logic [PW-1:0]   gnt_idx;
    logic            found;
    logic            grant;
    logic            fifo_full;
    logic            fifo_empty;

    // Round-robin search starting just after the last winner
    always_comb begin
        int unsigned sum;
        logic [PW-1:0] cand;
        found   = 1'b0;
        gnt_idx = rr_ptr_q;
        sum     = 0;
        cand    = '0;
        for (int unsigned off = 1; off <= NSRC; off++) begin
            sum = 32'(rr_ptr_q) + off;
            if (sum >= NSRC) sum = sum - NSRC;
            cand = PW'(sum);
            if (!found && pend_q[cand]) begin
                found   = 1'b1;
                gnt_idx = cand;
            end
        end
        // Full is judged on the current count; a same-cycle pop does not help
        grant = found && !fifo_full;
    end

    // Per-source capture decisions and drop accounting
    always_comb begin
        gnt_vec  = '0;
        latch_en = '0;
        pend_d   = pend_q;
        drop_cnt = '0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            gnt_vec[i]  = grant && (gnt_idx == PW'(i));
            // A slot being drained this cycle can accept a new word
            latch_en[i] = src_irq[i] && (!pend_q[i] || gnt_vec[i]);
            pend_d[i]   = src_irq[i] || (pend_q[i] && !gnt_vec[i]);
            if (src_irq[i] && pend_q[i] && !gnt_vec[i]) drop_cnt = drop_cnt + 4'd1;
        end
        ovf_d = sat_add8(clr_ovf ? 8'd0 : ovf_q, drop_cnt);
    end

    // Capture slots, pending flags, arbitration pointer and overflow counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NSRC; i++) slot_q[i] <= '0;
            pend_q   <= '0;
            rr_ptr_q <= PW'(NSRC - 1);
            ovf_q    <= '0;
        end else begin
            for (int unsigned i = 0; i < NSRC; i++) begin
                if (latch_en[i]) slot_q[i] <= src_data[i*W +: W];
            end
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
            if (grant) rr_ptr_q <= gnt_idx;
        end
    end

    io_evt_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (grant),
        .push_data (slot_q[gnt_idx]),
        .pop       (cpu_ack),
        .head      (cpu_data),
        .count     (fifo_level),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign cpu_irq = !fifo_empty;
    assign ovf_cnt = ovf_q;
    assign pending = pend_q;

endmodule

// File: tb/tb_io_event_arbiter.sv
// Directed bench for io_event_arbiter: expected FIFO words are queued when
// stimulus is driven and compared as the CPU side pops them.
module tb_io_event_arbiter;
    import io_evt_pkg::*;

    localparam int unsigned NSRC  = 4;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned W     = 32;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NSRC-1:0]        src_irq;
    logic [NSRC*W-1:0]      src_data;
    logic                   cpu_irq;
    logic [W-1:0]           cpu_data;
    logic                   cpu_ack;
    logic                   clr_ovf;
    logic [7:0]             ovf_cnt;
    logic [NSRC-1:0]        pending;
    logic [$clog2(DEPTH):0] fifo_level;

    int unsigned errors = 0;
    int unsigned checks = 0;
    logic [31:0] sb [$];

    io_event_arbiter #(
        .NSRC  (NSRC),
        .DEPTH (DEPTH),
        .W     (W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .src_irq    (src_irq),
        .src_data   (src_data),
        .cpu_irq    (cpu_irq),
        .cpu_data   (cpu_data),
        .cpu_ack    (cpu_ack),
        .clr_ovf    (clr_ovf),
        .ovf_cnt    (ovf_cnt),
        .pending    (pending),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk_evt(input logic [7:0] typ, input logic [7:0] pay);
        logic [31:0] w;
        w = '0;
        w[EVT_TYPE_MSB:EVT_TYPE_LSB]       = typ;
        w[EVT_PAYLOAD_MSB:EVT_PAYLOAD_LSB] = pay;
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    // Drive a one-cycle pulse on the sources in mask
    task automatic pulse(input logic [3:0] mask, input logic [31:0] d0, input logic [31:0] d1,
                         input logic [31:0] d2, input logic [31:0] d3);
        src_irq  = mask;
        src_data = {d3, d2, d1, d0};
        tick();
        src_irq  = '0;
    endtask

    // Compare the head against the scoreboard and acknowledge it
    task automatic pop_one(input string tag);
        logic [31:0] exp;
        exp = sb.pop_front();
        check(tag, cpu_data, exp);
        cpu_ack = 1'b1;
        tick();
        cpu_ack = 1'b0;
    endtask

    task automatic drain(input string tag);
        int unsigned waited;
        while (sb.size() > 0) begin
            waited = 0;
            while (!cpu_irq && waited < 20) begin
                tick();
                waited++;
            end
            if (!cpu_irq) begin
                check({tag, "_timeout"}, 32'(cpu_irq), 32'd1);
                sb.delete();
            end else begin
                pop_one(tag);
            end
        end
        check({tag, "_empty"}, 32'(cpu_irq), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst      = 1'b1;
        src_irq  = '0;
        src_data = '0;
        cpu_ack  = 1'b0;
        clr_ovf  = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        tick();

        check("rst_irq", 32'(cpu_irq), 32'd0);
        check("rst_data", cpu_data, 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_ovf", 32'(ovf_cnt), 32'd0);

        // Single key event: pend in t+1, irq/data in t+2, ack clears next cycle
        sb.push_back(mk_evt(EVT_KEY, 8'h05));
        pulse(4'b0001, mk_evt(EVT_KEY, 8'h05), 32'h0, 32'h0, 32'h0);
        check("t1_pend", 32'(pending), 32'h1);
        check("t1_irq_early", 32'(cpu_irq), 32'd0);
        tick();
        check("t1_irq", 32'(cpu_irq), 32'd1);
        pop_one("t1_data");
        check("t1_irq_after_ack", 32'(cpu_irq), 32'd0);
        check("t1_level_after_ack", 32'(fifo_level), 32'd0);

        // Four simultaneous events, twice: order 0..3 each time, one push per cycle
        do_reset();
        for (int i = 0; i < 4; i++) sb.push_back(32'h0000_00A0 + 32'(i));
        pulse(4'b1111, 32'hA0, 32'hA1, 32'hA2, 32'hA3);
        check("t2_level0", 32'(fifo_level), 32'd0);
        for (int n = 1; n <= 4; n++) begin
            tick();
            check("t2_level", 32'(fifo_level), 32'(n));
        end
        drain("t2a_order");
        for (int i = 0; i < 4; i++) sb.push_back(32'h0000_00B0 + 32'(i));
        pulse(4'b1111, 32'hB0, 32'hB1, 32'hB2, 32'hB3);
        drain("t2b_order");

        // Fairness: source 1 every cycle, source 2 once in cycle 2
        do_reset();
        sb.push_back(32'h1101);
        sb.push_back(32'h2200);
        sb.push_back(32'h1102);
        sb.push_back(32'h1104);
        sb.push_back(32'h1105);
        sb.push_back(32'h1106);
        for (int c = 1; c <= 6; c++) begin
            src_irq  = (c == 2) ? 4'b0110 : 4'b0010;
            src_data = {32'h0, 32'h2200, 32'h1100 + 32'(c), 32'h0};
            tick();
        end
        src_irq = '0;
        tick();
        check("t3_ovf", 32'(ovf_cnt), 32'd1);
        drain("t3_order");

        // Fill the FIFO with no acks; 10th pulse is dropped
        do_reset();
        for (int c = 1; c <= 9; c++) begin
            sb.push_back(32'h0400 + 32'(c));
            pulse(4'b0001, 32'h0400 + 32'(c), 32'h0, 32'h0, 32'h0);
        end
        tick();
        check("t4_level_full", 32'(fifo_level), 32'd8);
        check("t4_pend_full", 32'(pending), 32'h1);
        pulse(4'b0001, 32'h040A, 32'h0, 32'h0, 32'h0);
        check("t4_ovf", 32'(ovf_cnt), 32'd1);
        check("t4_level_still_full", 32'(fifo_level), 32'd8);
        pop_one("t4_head");
        check("t4_level_after_pop", 32'(fifo_level), 32'd7);
        check("t4_pend_after_pop", 32'(pending), 32'h1);
        tick();
        check("t4_level_refilled", 32'(fifo_level), 32'd8);
        check("t4_pend_cleared", 32'(pending), 32'h0);
        drain("t4_order");

        // Refill in the grant cycle: old word pushed, new word held, no drop
        do_reset();
        sb.push_back(mk_evt(EVT_TIMER, 8'h01));
        sb.push_back(mk_evt(EVT_TIMER, 8'h02));
        pulse(4'b1000, 32'h0, 32'h0, 32'h0, mk_evt(EVT_TIMER, 8'h01));
        pulse(4'b1000, 32'h0, 32'h0, 32'h0, mk_evt(EVT_TIMER, 8'h02));
        check("t5_pend_refill", 32'(pending), 32'h8);
        check("t5_ovf_refill", 32'(ovf_cnt), 32'd0);
        check("t5_level1", 32'(fifo_level), 32'd1);
        tick();
        check("t5_level2", 32'(fifo_level), 32'd2);
        check("t5_pend_done", 32'(pending), 32'h0);
        drain("t5_order");

        // Multi-drop sum, clr_ovf with a drop, then clr_ovf alone
        sb.push_back(32'hC0);
        sb.push_back(32'hC1);
        sb.push_back(32'hC2);
        pulse(4'b0111, 32'hC0, 32'hC1, 32'hC2, 32'h0);
        pulse(4'b0110, 32'h0, 32'hD1, 32'hD2, 32'h0);
        check("t5_ovf_two_drops", 32'(ovf_cnt), 32'd2);
        clr_ovf = 1'b1;
        pulse(4'b0100, 32'h0, 32'h0, 32'hE2, 32'h0);
        clr_ovf = 1'b0;
        check("t5_ovf_clr_with_drop", 32'(ovf_cnt), 32'd1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("t5_ovf_clr", 32'(ovf_cnt), 32'd0);
        drain("t5b_order");

        // Async reset mid-stream, then source 0 wins first
        do_reset();
        for (int c = 1; c <= 4; c++) pulse(4'b0001, 32'h0600 + 32'(c), 32'h0, 32'h0, 32'h0);
        pulse(4'b0110, 32'h0, 32'h0611, 32'h0612, 32'h0);
        pulse(4'b1100, 32'h0, 32'h0, 32'h0622, 32'h0623);
        check("t6_level_before", 32'(fifo_level), 32'd5);
        check("t6_pend_before", 32'(pending), 32'hC);
        check("t6_ovf_before", 32'(ovf_cnt), 32'd1);
        #3;
        rst = 1'b1;
        #1;
        check("t6_irq_async", 32'(cpu_irq), 32'd0);
        check("t6_data_async", cpu_data, 32'd0);
        check("t6_level_async", 32'(fifo_level), 32'd0);
        check("t6_pend_async", 32'(pending), 32'd0);
        check("t6_ovf_async", 32'(ovf_cnt), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) sb.push_back(32'h0000_0F00 + 32'(i));
        pulse(4'b1111, 32'hF00, 32'hF01, 32'hF02, 32'hF03);
        drain("t6_order");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
